// File: rtl/dot_acc_pkg.sv
// dot_acc_pkg: shared state type and default widths for the dot-product accumulator
package dot_acc_pkg;
    localparam int PROD_W_DEF = 32;
    localparam int ACC_W_DEF = 40;
    localparam int OUT_W_DEF = 16;
    localparam int SHIFT_DEF = 8;
    localparam int LEN_W = 4;
    typedef enum logic {IDLE, ACC} state_t;
endpackage

// File: rtl/dot_acc_fifo2.sv
// dot_acc_fifo2: two-entry result FIFO with 1-bit wrapping pointers
module dot_acc_fifo2 #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic wp;
    logic rp;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= 1'b0;
            rp <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp <= ~wp;
            end
            if (pop)
                rp <= ~rp;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
    assign dout = mem[rp];
endmodule

// File: rtl/dot_acc.sv
// dot_acc: streaming dot-product accumulator with rounding, saturation and a 2-deep result queue
module dot_acc
    import dot_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_valid,
    input  logic [PROD_W-1:0] p_data,
    input  logic              p_last,
    output logic              p_stall,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [OUT_W-1:0]  o_data,
    output logic              o_sat,
    output logic [LEN_W-1:0]  o_len
);
    localparam int RES_W = LEN_W + 1 + OUT_W;
    localparam logic [ACC_W:0] RND = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
    state_t state;
    state_t state_nx;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] p_ext;
    logic [LEN_W-1:0] len;
    logic done_pending;
    logic take;
    logic [1:0] fifo_count;
    logic signed [ACC_W:0] rsum;
    logic signed [ACC_W:0] rsh;
    logic ovf;
    logic [OUT_W-1:0] res;
    logic [RES_W-1:0] head;
    assign p_stall = ({1'b0, fifo_count} + {2'b00, done_pending}) >= 3'd2;
    assign take = p_valid && !p_stall;
    assign p_ext = {{(ACC_W-PROD_W){p_data[PROD_W-1]}}, p_data};
    always_comb begin
        state_nx = take ? (p_last ? IDLE : ACC) : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc <= '0;
            len <= '0;
            done_pending <= 1'b0;
        end else begin
            state <= state_nx;
            done_pending <= take && p_last;
            if (take) begin
                acc <= (state == IDLE) ? p_ext : acc + p_ext;
                len <= (state == IDLE) ? {{(LEN_W-1){1'b0}}, 1'b1}
                                       : len + {{(LEN_W-1){1'b0}}, ~&len};
            end
        end
    end
    // One extra bit so the rounding add cannot wrap before the shift.
    always_comb begin
        rsum = $signed({acc[ACC_W-1], acc} + RND);
        rsh = rsum >>> SHIFT;
        ovf = !(&rsh[ACC_W:OUT_W-1] || ~|rsh[ACC_W:OUT_W-1]);
        res = ovf ? {rsh[ACC_W], {(OUT_W-1){~rsh[ACC_W]}}} : rsh[OUT_W-1:0];
    end
    dot_acc_fifo2 #(.W(RES_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (done_pending),
        .pop   (o_valid && o_ready),
        .din   ({len, ovf, res}),
        .dout  (head),
        .count (fifo_count)
    );
    assign o_valid = fifo_count != 2'd0;
    assign {o_len, o_sat, o_data} = o_valid ? head : '0;
endmodule

// File: tb/tb_dot_acc.sv
// tb_dot_acc: directed vectors plus a randomized run against a bench-side reference model
module tb_dot_acc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic p_valid = 1'b0;
    logic p_last = 1'b0;
    logic [31:0] p_data = '0;
    logic p_stall;
    logic o_valid;
    logic o_ready;
    logic o_sat;
    logic [15:0] o_data;
    logic [3:0] o_len;
    logic rdy_fix = 1'b1;
    logic rnd_mode = 1'b0;
    logic rnd_rdy = 1'b0;
    logic mon_en = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    longint m_acc = 0;
    int m_len = 0;
    int m_cnt = 0;
    int m_dp = 0;
    int n_exp = 0;
    int n_got = 0;
    bit m_busy = 0;
    logic [20:0] exp_q[$];
    logic [20:0] got_q[$];

    always #5 clk = ~clk;
    assign o_ready = rnd_mode ? rnd_rdy : rdy_fix;

    dot_acc dut (
        .clk     (clk),
        .rst     (rst),
        .p_valid (p_valid),
        .p_data  (p_data),
        .p_last  (p_last),
        .p_stall (p_stall),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_sat   (o_sat),
        .o_len   (o_len)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [20:0] ref_res(input longint a, input int l);
        longint r;
        logic [3:0] l4;
        r = (a + 128) >>> 8;
        l4 = 4'(l);
        if (r > 32767) return {l4, 1'b1, 16'h7fff};
        if (r < -32768) return {l4, 1'b1, 16'h8000};
        return {l4, 1'b0, 16'(r)};
    endfunction

    always @(posedge clk) begin
        bit pop;
        bit take;
        if (rst) begin
            m_acc = 0;
            m_len = 0;
            m_busy = 0;
            m_cnt = 0;
            m_dp = 0;
            exp_q.delete();
        end else begin
            pop = m_cnt > 0 && o_ready;
            take = p_valid && (m_cnt + m_dp < 2);
            if (pop) exp_q.delete(0);
            m_cnt = m_cnt + m_dp - int'(pop);
            m_dp = 0;
            if (take) begin
                m_acc = (m_busy ? m_acc : 64'sd0) + longint'($signed(p_data));
                m_len = m_busy ? (m_len < 15 ? m_len + 1 : 15) : 1;
                m_busy = !p_last;
                if (p_last) begin
                    exp_q.push_back(ref_res(m_acc, m_len));
                    m_dp = 1;
                    n_exp++;
                end
            end
        end
        if (o_valid && o_ready) begin
            got_q.push_back({o_len, o_sat, o_data});
            n_got++;
        end
    end

    always @(negedge clk) rnd_rdy = 1'($urandom_range(0, 1));

    always @(negedge clk) if (mon_en) begin
        check("o_valid", o_valid, m_cnt > 0);
        check("p_stall", p_stall, m_cnt + m_dp >= 2);
        if (m_cnt > 0) check("head", {o_len, o_sat, o_data}, exp_q[0]);
    end

    task automatic beat(input logic [31:0] d, input logic l);
        int k = 0;
        p_valid = 1'b1;
        p_data = d;
        p_last = l;
        while (p_stall && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("beat_wait", p_stall, 0);
        @(negedge clk);
        p_valid = 1'b0;
        p_last = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [20:0] exp);
        int k = 0;
        while (got_q.size() == 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (got_q.size() == 0) check({tag, "_wait"}, 64'(got_q.size()), 1);
        else check(tag, got_q.pop_front(), exp);
    endtask

    initial begin
        int len;
        int k;
        repeat (2) @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_out", {o_len, o_sat, o_data}, 0);
        check("rst_stall", p_stall, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        // single-beat vector, latency of two edges
        rdy_fix = 1'b0;
        beat(32'd384, 1'b1);
        check("single_lat1", o_valid, 0);
        @(negedge clk);
        check("single_lat2", o_valid, 1);
        check("single_res", {o_len, o_sat, o_data}, {4'd1, 1'b0, 16'd2});
        rdy_fix = 1'b1;
        expect_res("single_pop", {4'd1, 1'b0, 16'd2});
        // back-to-back vectors
        repeat (3) beat(32'd65536, 1'b0);
        beat(32'd65536, 1'b1);
        beat(-32'sd384, 1'b1);
        expect_res("vec4", {4'd4, 1'b0, 16'd1024});
        expect_res("neg1", {4'd1, 1'b0, 16'hffff});
        // saturation both ways
        beat(32'h7fffffff, 1'b0);
        beat(32'h7fffffff, 1'b1);
        beat(32'h80000000, 1'b0);
        beat(32'h80000000, 1'b1);
        expect_res("sat_pos", {4'd2, 1'b1, 16'h7fff});
        expect_res("sat_neg", {4'd2, 1'b1, 16'h8000});
        // back-pressure with the queue full
        rdy_fix = 1'b0;
        beat(32'd256, 1'b1);
        beat(32'd512, 1'b1);
        p_valid = 1'b1;
        p_data = 32'd768;
        p_last = 1'b1;
        check("full_stall", p_stall, 1);
        repeat (4) @(negedge clk);
        check("full_hold_stall", p_stall, 1);
        check("full_hold_head", {o_len, o_sat, o_data}, {4'd1, 1'b0, 16'd1});
        check("full_no_pop", 64'(got_q.size()), 0);
        rdy_fix = 1'b1;
        beat(32'd768, 1'b1);
        expect_res("full_r1", {4'd1, 1'b0, 16'd1});
        expect_res("full_r2", {4'd1, 1'b0, 16'd2});
        expect_res("full_r3", {4'd1, 1'b0, 16'd3});
        // reset mid-vector discards the partial sum
        beat(32'd1000, 1'b0);
        beat(32'd1000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_valid", o_valid, 0);
        check("mrst_stall", p_stall, 0);
        check("mrst_out", {o_len, o_sat, o_data}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("mrst_no_out", 64'(got_q.size()), 0);
        beat(32'd256, 1'b1);
        expect_res("post_rst", {4'd1, 1'b0, 16'd1});
        // randomized traffic; first vector long enough to saturate o_len
        rnd_mode = 1'b1;
        for (int v = 0; v < 40; v++) begin
            len = (v == 0) ? 20 : int'($urandom_range(1, 20));
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                beat(32'($urandom_range(0, 200000)) - 32'd100000, b == len - 1);
            end
        end
        rnd_mode = 1'b0;
        rdy_fix = 1'b1;
        k = 0;
        while (n_got != n_exp && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rnd_count", 64'(n_got), 64'(n_exp));
        check("rnd_drain", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/dot_acc.md
DOT_ACC -- requirements
Module: dot_acc

Interface
REQ-001 SHALL have parameter PROD_W, default 32, meaning signed product width from the upstream multiplier.
REQ-002 SHALL have parameter ACC_W, default 40, meaning accumulator width.
REQ-003 SHALL have parameter OUT_W, default 16, meaning result width.
REQ-004 SHALL have parameter SHIFT, default 8, meaning right-shift applied to the final sum; legal range 1..ACC_W-OUT_W.
REQ-005 SHALL have port clk  input  1  meaning sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-007 SHALL have port p_valid  input  1  meaning product beat valid.
REQ-008 SHALL have port p_data  input  PROD_W  meaning signed product.
REQ-009 SHALL have port p_last  input  1  meaning final beat of a vector.
REQ-010 SHALL have port p_stall  output  1  meaning back-pressure; the multiplier pipe enable is driven from !p_stall.
REQ-011 SHALL have port o_valid  output  1  meaning result available.
REQ-012 SHALL have port o_ready  input  1  meaning consumer accepts the result.
REQ-013 SHALL have port o_data  output  OUT_W  meaning signed rounded, saturated dot product.
REQ-014 SHALL have port o_sat  output  1  meaning o_data was clipped.
REQ-015 SHALL have port o_len  output  4  meaning beat count of the vector, saturating at 15.

Function
REQ-016 SHALL accept a beat only when p_valid && !p_stall; beats with p_stall=1 are ignored.
REQ-017 SHALL use a two-state FSM, IDLE and ACC: an accepted non-last beat in IDLE goes to ACC; an accepted last beat returns to IDLE.
REQ-018 SHALL load acc with sign-extended p_data on the first beat (IDLE), with no add and no clear cycle.
REQ-019 SHALL compute acc + sign-extended p_data in ACC, so back-to-back vectors run at one beat per cycle.
REQ-020 SHALL treat a single beat with p_last=1 in IDLE as a complete one-element vector.
REQ-021 SHALL, when the last beat is accepted at edge E, set done_pending at E and push the result into a 2-entry output FIFO at E+1, so o_valid is high after E+1.
REQ-022 SHALL compute the result as (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift), then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1] with o_sat=1 when clipped.
REQ-023 SHALL pop the FIFO head when o_valid && o_ready; o_data, o_sat and o_len come from the head and are held stable while o_valid=1 and o_ready=0.
REQ-024 SHALL drive p_stall = (fifo_count + done_pending >= 2), combinationally from registers only.
REQ-025 SHALL allow a push and a pop in the same cycle without changing the count.
REQ-026 SHALL never overflow the FIFO and never drop an accepted beat.
REQ-027 SHALL wrap the FIFO pointers modulo 2.

Reset
REQ-028 SHALL, on rst=1 at an edge, set FSM=IDLE, acc=0, the beat counter to 0, done_pending=0 and fifo_count=0, discarding any partial vector.
REQ-029 SHALL have these output values during and after reset: o_valid=0, o_data=0, o_sat=0, o_len=0, p_stall=0.

Structure
REQ-030 SHALL take the FSM state enum and the default widths from the shared QR package.
REQ-031 SHALL use one sub-module, dot_acc_fifo2, as the 2-entry output FIFO holding {o_len, o_sat, o_data}.
REQ-032 SHALL keep the rounding and saturation logic combinational inside dot_acc.

Verification
REQ-033 SHALL test a single beat p_data=384 with last=1, expecting o_data=2, o_sat=0, o_len=1, with o_valid two edges after acceptance.
REQ-034 SHALL test 4 beats of 65536, expecting o_data=1024, o_len=4; then an immediate single beat of -384, expecting o_data=0xFFFF (-1).
REQ-035 SHALL test 2 beats of 0x7FFFFFFF, expecting o_data=0x7FFF, o_sat=1; and 2 beats of 0x80000000, expecting o_data=0x8000, o_sat=1.
REQ-036 SHALL test o_ready=0 with 3 single-beat vectors offered: p_stall=1 once two results are queued or pending, the third beat is held, and on releasing o_ready all 3 results emerge in order.
REQ-037 SHALL test rst pulsed after 2 beats of a 4-beat vector: no output results, and a following 1-beat vector of 256 yields o_data=1, o_len=1.
REQ-038 SHALL test random p_valid, o_ready and vector lengths 1..20 against a reference model, including simultaneous push/pop and o_len saturating at 15.
